// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: packet-granular round-robin arbiter for one fabric egress.
// Ports: clk, rst (async, active-high), clr (sync flush); per-requester
//   req/eop; stall backpressure. Outputs: one-hot grant, grant_idx,
//   busy, beat_cnt (beats moved in current packet), timeout_err pulse.
module rr_pkt_arb #(
  parameter int NUM_PORT      = 4,
  parameter int LOG_NUM_PORT  = 2,
  parameter int MAX_BEATS     = 64,
  parameter int LOG_MAX_BEATS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_PORT-1:0]      req,
  input  logic [NUM_PORT-1:0]      eop,
  input  logic                     stall,
  output logic [NUM_PORT-1:0]      grant,
  output logic [LOG_NUM_PORT-1:0]  grant_idx,
  output logic                     busy,
  output logic [LOG_MAX_BEATS-1:0] beat_cnt,
  output logic                     timeout_err
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [LOG_NUM_PORT-1:0]  ptr, ptr_n;
  logic [LOG_NUM_PORT-1:0]  idx_n;
  logic [LOG_NUM_PORT-1:0]  sel;
  logic [LOG_NUM_PORT-1:0]  k;
  logic [NUM_PORT-1:0]      grant_n;
  logic [LOG_MAX_BEATS-1:0] cnt_n;
  logic                     to_n;
  logic                     found;
  logic                     xfer;
  logic                     last;

  // Rotating priority search starting at ptr; index arithmetic wraps
  // naturally because NUM_PORT is a power of two.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      k = ptr + LOG_NUM_PORT'(i);
      if (!found && req[k]) begin
        found = 1'b1;
        sel   = k;
      end
    end
  end

  assign xfer = (state == HOLD) && req[grant_idx] && !stall;
  assign last = (beat_cnt == LOG_MAX_BEATS'(MAX_BEATS - 1));

  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n   = grant_idx;
    cnt_n   = beat_cnt;
    ptr_n   = ptr;
    to_n    = 1'b0;
    if (clr) begin
      state_n = IDLE;
      grant_n = '0;
      idx_n   = '0;
      cnt_n   = '0;
      ptr_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state_n = HOLD;
            grant_n = NUM_PORT'(1) << sel;
            idx_n   = sel;
            cnt_n   = '0;
          end
        end
        HOLD: begin
          if (xfer) begin
            if (eop[grant_idx] || last) begin
              // eop release and forced release share the same path;
              // only a beat without eop flags the timeout.
              state_n = IDLE;
              grant_n = '0;
              cnt_n   = '0;
              ptr_n   = grant_idx + LOG_NUM_PORT'(1);
              to_n    = !eop[grant_idx];
            end else begin
              cnt_n = beat_cnt + LOG_MAX_BEATS'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      beat_cnt    <= '0;
      ptr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      beat_cnt    <= cnt_n;
      ptr         <= ptr_n;
      timeout_err <= to_n;
    end
  end

  assign busy = (state == HOLD);

endmodule
